alu_muldiv: RTL and testbench

- Parametrised successor of the single-cycle datapath ALU.
- Adds registered outputs, extended logic ops, and signed/unsigned compare.
- Adds an iterative unsigned multiply/divide unit with HI/LO registers (MIPS MULTU/DIVU/MFHI/MFLO) behind a start/busy/done handshake.
- Sits in the EX stage of the multi-cycle MIPS core; the control FSM stalls while busy is high.

---
 rtl/alu_muldiv.sv | 155 +++++++++++++++
 tb/tb_alu_muldiv.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// EX-stage ALU with registered outputs and an iterative MULTU/DIVU unit.
// Single-cycle ops finish in one cycle; mul/div use a start/busy/done handshake.
module alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       ALUop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } state_t;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0011;
  localparam logic [3:0] OP_SLTU  = 4'b0100;
  localparam logic [3:0] OP_SLT   = 4'b0101;
  localparam logic [3:0] OP_XOR   = 4'b0110;
  localparam logic [3:0] OP_NOR   = 4'b0111;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;
  localparam logic [3:0] OP_MFHI  = 4'b1010;
  localparam logic [3:0] OP_MFLO  = 4'b1011;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   opd;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mul_nxt;
  logic [2*WIDTH-1:0] div_nxt;
  logic [2*WIDTH-1:0] step_nxt;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_diff;
  logic [WIDTH-1:0]   alu_res;

  always_comb begin
    alu_res = '0;
    case (ALUop)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_SLTU: alu_res = WIDTH'(a < b);
      OP_SLT:  alu_res = WIDTH'($signed(a) < $signed(b));
      OP_XOR:  alu_res = a ^ b;
      OP_NOR:  alu_res = ~(a | b);
      OP_MFHI: alu_res = hi;
      OP_MFLO: alu_res = lo;
      default: alu_res = '0;
    endcase
  end

  // acc = {partial product, remaining multiplier bits}; carry lands on top
  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]};
    if (acc[0]) begin
      mul_sum = mul_sum + {1'b0, opd};
    end
    mul_nxt = {mul_sum, acc[WIDTH-1:1]};
  end

  // acc = {remainder, dividend bits shifting out / quotient bits in}
  always_comb begin
    div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opd};
    if (!div_diff[WIDTH]) begin
      div_nxt = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      div_nxt = {acc[2*WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    step_nxt = (state == S_DIV) ? div_nxt : mul_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      opd         <= '0;
      acc         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      Result      <= '0;
      zero        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            div_by_zero <= 1'b0;
            if (ALUop == OP_MULTU) begin
              opd   <= a;
              acc   <= {{WIDTH{1'b0}}, b};
              cnt   <= CNT_W'(WIDTH);
              busy  <= 1'b1;
              state <= S_MUL;
            end else if (ALUop == OP_DIVU && b == '0) begin
              lo          <= '1;
              hi          <= a;
              Result      <= '1;
              zero        <= 1'b0;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
            end else if (ALUop == OP_DIVU) begin
              opd   <= b;
              acc   <= {{WIDTH{1'b0}}, a};
              cnt   <= CNT_W'(WIDTH);
              busy  <= 1'b1;
              state <= S_DIV;
            end else begin
              Result <= alu_res;
              zero   <= (alu_res == '0);
              done   <= 1'b1;
            end
          end
        end
        S_MUL, S_DIV: begin
          acc <= step_nxt;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            hi     <= step_nxt[2*WIDTH-1:WIDTH];
            lo     <= step_nxt[WIDTH-1:0];
            Result <= step_nxt[WIDTH-1:0];
            zero   <= (step_nxt[WIDTH-1:0] == '0);
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: directed cases, abort/ignore cases,
// random ops against an arithmetic reference model, plus a WIDTH=8 instance.
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] res;
  logic        zero;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        dbz;

  logic        rst8;
  logic        start8;
  logic [3:0]  op8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        busy8;
  logic        done8;
  logic [7:0]  res8;
  logic        zero8;
  logic [7:0]  hi8;
  logic [7:0]  lo8;
  logic        dbz8;

  always #5 clk = ~clk;

  alu_muldiv #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .ALUop(op),
    .a(a), .b(b), .busy(busy), .done(done), .Result(res),
    .zero(zero), .hi(hi), .lo(lo), .div_by_zero(dbz)
  );

  alu_muldiv #(.WIDTH(8), .CNT_W(4)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .ALUop(op8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .Result(res8),
    .zero(zero8), .hi(hi8), .lo(lo8), .div_by_zero(dbz8)
  );

  typedef struct {
    logic [31:0] r;
    logic [31:0] h;
    logic [31:0] l;
    logic        z;
    logic        d;
  } exp_t;

  exp_t        q[$];
  exp_t        em;
  int          total = 0;
  int          bad = 0;
  logic [31:0] mhi = '0;
  logic [31:0] mlo = '0;

  task automatic chk(string n, logic [63:0] act, logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, want, $time);
    end
  endtask

  // reference model: plain arithmetic on the architectural rules
  task automatic model(input logic [3:0] o, input logic [31:0] x,
                       input logic [31:0] y);
    exp_t        e;
    logic [63:0] p;
    e.d = 1'b0;
    case (o)
      4'd0: e.r = x & y;
      4'd1: e.r = x | y;
      4'd2: e.r = x + y;
      4'd3: e.r = x - y;
      4'd4: e.r = (x < y) ? 32'd1 : 32'd0;
      4'd5: e.r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd6: e.r = x ^ y;
      4'd7: e.r = ~(x | y);
      4'd8: begin
        p   = 64'(x) * 64'(y);
        mhi = p[63:32];
        mlo = p[31:0];
        e.r = mlo;
      end
      4'd9: begin
        if (y == 0) begin
          mlo = 32'hFFFF_FFFF;
          mhi = x;
          e.d = 1'b1;
        end else begin
          mlo = x / y;
          mhi = x % y;
        end
        e.r = mlo;
      end
      4'd10: e.r = mhi;
      4'd11: e.r = mlo;
      default: e.r = 32'd0;
    endcase
    e.z = (e.r == 0);
    e.h = mhi;
    e.l = mlo;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (q.size() == 0) begin
        chk("spurious_done", 64'd1, 64'd0);
      end else begin
        em = q.pop_front();
        chk("result", 64'(res), 64'(em.r));
        chk("zero", 64'(zero), 64'(em.z));
        chk("hi", 64'(hi), 64'(em.h));
        chk("lo", 64'(lo), 64'(em.l));
        chk("div_by_zero", 64'(dbz), 64'(em.d));
      end
    end
  end

  // issue one op; called at a negedge, returns at the negedge done is seen
  task automatic run_op(input logic [3:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int dist_at = 0,
                        input int rst_at = 0);
    int   cyc;
    int   bcnt;
    logic seen;
    logic iter;
    iter = (o == 4'd8) || (o == 4'd9 && y != 0);
    if (rst_at == 0) model(o, x, y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    cyc   = 0;
    bcnt  = 0;
    seen  = 1'b0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (busy) bcnt++;
      if (done) seen = 1'b1;
      start = (cyc == dist_at);
      if (cyc == dist_at) begin
        op = 4'd2;
        a  = 32'd99;
        b  = 32'd1;
      end
      if (cyc == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_hi", 64'(hi), 64'd0);
        chk("abort_lo", 64'(lo), 64'd0);
        chk("abort_result", 64'(res), 64'd0);
        rst = 1'b0;
        mhi = '0;
        mlo = '0;
        repeat (40) @(negedge clk);
        return;
      end
    end
    if (!seen) begin
      chk("timeout", 64'd1, 64'd0);
    end else begin
      chk("latency", 64'(cyc), iter ? 64'd33 : 64'd1);
      chk("busy_cycles", 64'(bcnt), iter ? 64'd32 : 64'd0);
    end
  endtask

  task automatic run8(input logic [3:0] o, input logic [7:0] x,
                      input logic [7:0] y, input logic [7:0] eh,
                      input logic [7:0] el);
    int   cyc;
    int   bcnt;
    logic seen;
    start8 = 1'b1;
    op8    = o;
    a8     = x;
    b8     = y;
    cyc    = 0;
    bcnt   = 0;
    seen   = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      start8 = 1'b0;
      if (busy8) bcnt++;
      if (done8) seen = 1'b1;
    end
    if (!seen) begin
      chk("w8_timeout", 64'd1, 64'd0);
    end else begin
      chk("w8_latency", 64'(cyc), 64'd9);
      chk("w8_busy_cycles", 64'(bcnt), 64'd8);
      chk("w8_hi", 64'(hi8), 64'(eh));
      chk("w8_lo", 64'(lo8), 64'(el));
      chk("w8_result", 64'(res8), 64'(el));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    rst    = 1'b1;
    start  = 1'b0;
    op     = '0;
    a      = '0;
    b      = '0;
    rst8   = 1'b1;
    start8 = 1'b0;
    op8    = '0;
    a8     = '0;
    b8     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_result", 64'(res), 64'd0);
    chk("rst_zero", 64'(zero), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dbz", 64'(dbz), 64'd0);
    rst  = 1'b0;
    rst8 = 1'b0;
    @(negedge clk);

    run_op(4'd2, 32'd5, 32'd7);
    run_op(4'd3, 32'd3, 32'd3);
    run_op(4'd5, 32'hFFFF_FFFF, 32'd1);
    run_op(4'd4, 32'hFFFF_FFFF, 32'd1);
    run_op(4'd7, 32'd0, 32'd0);
    run_op(4'd8, 32'hFFFF_FFFF, 32'd2);
    run_op(4'd10, 32'd0, 32'd0);
    run_op(4'd9, 32'd100, 32'd7);
    run_op(4'd2, 32'd20, 32'd22);
    run_op(4'd9, 32'd9, 32'd0);
    run_op(4'd11, 32'd0, 32'd0);
    run_op(4'd12, 32'd1, 32'd2);
    run_op(4'd8, 32'd3, 32'd4, 5);
    run_op(4'd8, 32'd3, 32'd4, 0, 10);
    run_op(4'd11, 32'd0, 32'd0);

    for (int i = 0; i < 80; i++) begin
      ro = 4'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'hFFFF_FFFF;
      run_op(ro, ra, rb);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    run8(4'd8, 8'hFF, 8'hFF, 8'hFE, 8'h01);
    run8(4'd9, 8'd200, 8'd7, 8'd4, 8'd28);

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
